// File: rtl/rom_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl_if : HPS ioctl download stream in, core-side ROM write bus out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rom_load_ctrl_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic [3:0]        dn_wr;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr
  );
endinterface

`default_nettype wire

// File: rtl/rom_load_ctrl.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl : routes the HPS ROM download into four core ROM regions and
// holds the core in reset until a validated image is resident.
// Optional: define ROM_CHKSUM_EN to add a 16-bit additive checksum check.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rom_load_ctrl #(
  parameter int unsigned       ADDR_W      = 17,
  parameter logic [ADDR_W-1:0] TOTAL_BYTES = 17'h18000,
  parameter logic [ADDR_W-1:0] R1_BASE     = 17'h08000,
  parameter logic [ADDR_W-1:0] R2_BASE     = 17'h0C000,
  parameter logic [ADDR_W-1:0] R3_BASE     = 17'h10000,
  parameter int unsigned       HOLD_CYC    = 16
`ifdef ROM_CHKSUM_EN
  , parameter logic [15:0]     EXP_SUM     = 16'h0000
`endif
) (
  input  wire logic              clk_sys,
  input  wire logic              reset,
  rom_load_ctrl_if.slave         bus,
  output logic                   core_reset,
  output logic                   load_done,
  output logic                   load_error,
  output logic [ADDR_W-1:0]      byte_cnt
`ifdef ROM_CHKSUM_EN
  , output logic [15:0]          chksum
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [15:0]       HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [ADDR_W-1:0] CNT_ONE   = 1;

  logic [2:0]        state_q, state_d;
  logic              dl_q;
  logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
  logic [7:0]        dn_data_q, dn_data_d;
  logic [3:0]        dn_wr_q, dn_wr_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              ovf_q, ovf_d;
  logic              load_error_q, load_error_d;
  logic [15:0]       hold_q, hold_d;
  logic              core_reset_q, core_reset_d;
  logic              load_done_q, load_done_d;
`ifdef ROM_CHKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  logic              rise, fall, in_range, image_ok;
  logic [ADDR_W-1:0] addr_lo;

  assign rise     = bus.ioctl_download & ~dl_q;
  assign fall     = ~bus.ioctl_download & dl_q;
  assign addr_lo  = bus.ioctl_addr[ADDR_W-1:0];
  // Any set bit above the core address width is out of range, regardless of the low bits.
  assign in_range = (bus.ioctl_addr[24:ADDR_W] == '0) && (addr_lo < TOTAL_BYTES);

`ifdef ROM_CHKSUM_EN
  assign image_ok = (byte_cnt_q == TOTAL_BYTES) && !ovf_q && (sum_q == EXP_SUM);
`else
  assign image_ok = (byte_cnt_q == TOTAL_BYTES) && !ovf_q;
`endif

  always_comb begin
    state_d      = state_q;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_wr_d      = 4'b0000;
    byte_cnt_d   = byte_cnt_q;
    ovf_d        = ovf_q;
    load_error_d = load_error_q;
    hold_d       = hold_q;
`ifdef ROM_CHKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (bus.ioctl_wr) begin
          if (in_range) begin
            dn_data_d = bus.ioctl_dout;
            if (addr_lo >= R3_BASE) begin
              dn_wr_d   = 4'b1000;
              dn_addr_d = addr_lo - R3_BASE;
            end else if (addr_lo >= R2_BASE) begin
              dn_wr_d   = 4'b0100;
              dn_addr_d = addr_lo - R2_BASE;
            end else if (addr_lo >= R1_BASE) begin
              dn_wr_d   = 4'b0010;
              dn_addr_d = addr_lo - R1_BASE;
            end else begin
              dn_wr_d   = 4'b0001;
              dn_addr_d = addr_lo;
            end
            if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_ONE;
`ifdef ROM_CHKSUM_EN
            sum_d = sum_q + {8'h00, bus.ioctl_dout};
`endif
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (fall) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (image_ok) begin
          state_d      = S_HOLD;
          hold_d       = 16'd0;
          load_error_d = 1'b0;
        end else begin
          state_d      = S_ERROR;
          load_error_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 16'd1;
      end
      default: ;
    endcase

    // A new download pre-empts whatever the controller was doing.
    if (rise) begin
      state_d      = S_LOAD;
      byte_cnt_d   = '0;
      ovf_d        = 1'b0;
      load_error_d = 1'b0;
`ifdef ROM_CHKSUM_EN
      sum_d        = 16'h0000;
`endif
    end

    core_reset_d = (state_d != S_RUN);
    load_done_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dl_q         <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= 8'h00;
      dn_wr_q      <= 4'b0000;
      byte_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      load_error_q <= 1'b0;
      hold_q       <= 16'd0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
`ifdef ROM_CHKSUM_EN
      sum_q        <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      dl_q         <= bus.ioctl_download;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      byte_cnt_q   <= byte_cnt_d;
      ovf_q        <= ovf_d;
      load_error_q <= load_error_d;
      hold_q       <= hold_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
`ifdef ROM_CHKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign bus.dn_addr = dn_addr_q;
  assign bus.dn_data = dn_data_q;
  assign bus.dn_wr   = dn_wr_q;
  assign core_reset  = core_reset_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;
  assign byte_cnt    = byte_cnt_q;
`ifdef ROM_CHKSUM_EN
  assign chksum      = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_load_ctrl : directed bench for rom_load_ctrl on a scaled-down image
// (0x180 bytes, regions at 0x000/0x080/0x0C0/0x100).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rom_load_ctrl;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned HOLD   = 16;
  localparam int          TOTAL  = 'h180;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              core_reset, load_done, load_error;
  logic [ADDR_W-1:0] byte_cnt;
`ifdef ROM_CHKSUM_EN
  logic [15:0]       chksum;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk_sys = ~clk_sys;

  rom_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  rom_load_ctrl #(
    .ADDR_W      (ADDR_W),
    .TOTAL_BYTES (17'h00180),
    .R1_BASE     (17'h00080),
    .R2_BASE     (17'h000C0),
    .R3_BASE     (17'h00100),
    .HOLD_CYC    (HOLD)
`ifdef ROM_CHKSUM_EN
    , .EXP_SUM   (16'h9F40)
`endif
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_cnt   (byte_cnt)
`ifdef ROM_CHKSUM_EN
    , .chksum   (chksum)
`endif
  );

  // Each cycle a strobe is seen counts once, so a stretched strobe shows up as extra pulses.
  always @(negedge clk_sys) if (|bus.dn_wr) pulses = pulses + 1;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Writes bytes 0..n-1 (data = low address byte), one strobe every 4 cycles.
  // The final strobe coincides with the download falling, unless an overflow
  // write to address TOTAL is appended, which then takes that role.
  task automatic send_bytes(input int n, input bit ovf, input bit directed);
    logic [3:0]  ew;
    logic [16:0] ea;
    bit          last;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1) && !ovf;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'(i);
      bus.ioctl_wr   = 1'b1;
      if (last) bus.ioctl_download = 1'b0;
      tick();
      bus.ioctl_wr = 1'b0;
      if (directed) begin
        ew = 4'b0000;
        ea = 17'h0;
        case (i)
          'h000: begin ew = 4'b0001; ea = 17'h00; end
          'h07F: begin ew = 4'b0001; ea = 17'h7F; end
          'h080: begin ew = 4'b0010; ea = 17'h00; end
          'h0BF: begin ew = 4'b0010; ea = 17'h3F; end
          'h0C0: begin ew = 4'b0100; ea = 17'h00; end
          'h0FF: begin ew = 4'b0100; ea = 17'h3F; end
          'h100: begin ew = 4'b1000; ea = 17'h00; end
          'h17F: begin ew = 4'b1000; ea = 17'h7F; end
          default: ;
        endcase
        if (ew != 4'b0000) begin
          chk($sformatf("dn_wr@%0h", i), 32'(bus.dn_wr), 32'(ew));
          chk($sformatf("dn_addr@%0h", i), 32'(bus.dn_addr), 32'(ea));
          chk($sformatf("dn_data@%0h", i), 32'(bus.dn_data), 32'(i & 'hFF));
        end
      end
      if (!last) repeat (3) tick();
    end
    if (ovf) begin
      bus.ioctl_addr     = 25'(TOTAL);
      bus.ioctl_dout     = 8'hEE;
      bus.ioctl_wr       = 1'b1;
      bus.ioctl_download = 1'b0;
      tick();
      bus.ioctl_wr = 1'b0;
      chk("dn_wr_ovf", 32'(bus.dn_wr), 32'h0);
    end
  endtask

  // Called just after the edge that sampled the download fall.
  task automatic expect_run(input string tag);
    repeat (HOLD) tick();
    chk({tag, "_hold_done"}, 32'(load_done), 32'h0);
    chk({tag, "_hold_rst"}, 32'(core_reset), 32'h1);
    tick();
    chk({tag, "_run_done"}, 32'(load_done), 32'h1);
    chk({tag, "_run_rst"}, 32'(core_reset), 32'h0);
    chk({tag, "_run_err"}, 32'(load_error), 32'h0);
    chk({tag, "_run_cnt"}, 32'(byte_cnt), 32'h180);
  endtask

  initial begin
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'h00;
    repeat (3) tick();

    chk("rst_dn_addr", 32'(bus.dn_addr), 32'h0);
    chk("rst_dn_data", 32'(bus.dn_data), 32'h0);
    chk("rst_dn_wr", 32'(bus.dn_wr), 32'h0);
    chk("rst_core_reset", 32'(core_reset), 32'h1);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_load_error", 32'(load_error), 32'h0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'h0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_core_reset", 32'(core_reset), 32'h1);

    // Full good load with directed region checks and strobe count.
    pulses = 0;
    bus.ioctl_download = 1'b1;
    repeat (2) tick();
    send_bytes(TOTAL, 1'b0, 1'b1);
    expect_run("good1");
    chk("good1_pulses", 32'(pulses), 32'h180);
`ifdef ROM_CHKSUM_EN
    chk("good1_chksum", 32'(chksum), 32'h9F40);
`endif

    // Reload from RUN, then stop one byte short.
    bus.ioctl_download = 1'b1;
    tick();
    chk("reload_core_reset", 32'(core_reset), 32'h1);
    chk("reload_load_done", 32'(load_done), 32'h0);
    tick();
    send_bytes(TOTAL - 1, 1'b0, 1'b0);
    tick();
    chk("short_err", 32'(load_error), 32'h1);
    chk("short_core_reset", 32'(core_reset), 32'h1);
    chk("short_done", 32'(load_done), 32'h0);
    chk("short_cnt", 32'(byte_cnt), 32'h17F);
    repeat (HOLD + 4) tick();
    chk("short_stays_rst", 32'(core_reset), 32'h1);

    // Full length plus one out-of-range write.
    pulses = 0;
    bus.ioctl_download = 1'b1;
    tick();
    chk("ovf_entry_err_clr", 32'(load_error), 32'h0);
    tick();
    send_bytes(TOTAL, 1'b1, 1'b0);
    tick();
    chk("ovf_err", 32'(load_error), 32'h1);
    chk("ovf_cnt", 32'(byte_cnt), 32'h180);
    chk("ovf_done", 32'(load_done), 32'h0);
    chk("ovf_pulses", 32'(pulses), 32'h180);

    // Upper address bit set is out of range even with zero low bits.
    bus.ioctl_download = 1'b1;
    repeat (2) tick();
    bus.ioctl_addr = 25'h100_0000;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    chk("hiaddr_dn_wr", 32'(bus.dn_wr), 32'h0);
    chk("hiaddr_cnt", 32'(byte_cnt), 32'h0);
    repeat (3) tick();
    send_bytes(TOTAL, 1'b0, 1'b0);
    tick();
    chk("hiaddr_err", 32'(load_error), 32'h1);

    // Good load recovering from ERROR.
    bus.ioctl_download = 1'b1;
    repeat (2) tick();
    send_bytes(TOTAL, 1'b0, 1'b0);
    expect_run("good2");

    // Reset mid-load with a write pending on the reset edge.
    bus.ioctl_download = 1'b1;
    repeat (2) tick();
    send_bytes('h100, 1'b1, 1'b0);
    bus.ioctl_download = 1'b1;
    reset = 1'b1;
    bus.ioctl_addr = 25'h0;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    chk("midrst_dn_wr", 32'(bus.dn_wr), 32'h0);
    chk("midrst_dn_addr", 32'(bus.dn_addr), 32'h0);
    chk("midrst_dn_data", 32'(bus.dn_data), 32'h0);
    chk("midrst_cnt", 32'(byte_cnt), 32'h0);
    chk("midrst_core_reset", 32'(core_reset), 32'h1);
    chk("midrst_err", 32'(load_error), 32'h0);
    chk("midrst_done", 32'(load_done), 32'h0);
    // Download still high out of reset: LOAD is entered on the first edge after release.
    reset = 1'b0;
    tick();
    send_bytes(TOTAL, 1'b0, 1'b0);
    expect_run("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the HPS ROM download (ioctl stream) into the arcade core's ROM regions.
- Decodes each byte to one of four region write strobes and holds the game core in reset until the image is complete and validated.
- Releases reset after a programmable hold.
- Sits between hps_io and the game core; replaces the direct "reset | ioctl_download" wiring.

Parameters:
- ADDR_W, 17, width of core-side download address.
- TOTAL_BYTES, 17'h18000, exact required image length in bytes.
- R1_BASE, 17'h08000, first byte of region 1; region 0 starts at 0.
- R2_BASE, 17'h0C000, first byte of region 2.
- R3_BASE, 17'h10000, first byte of region 3; region 3 runs to TOTAL_BYTES-1.
- HOLD_CYC, 16, clk_sys cycles core_reset stays high after a valid load.
- EXP_SUM, 16'h0000, expected 16-bit additive checksum (used only with ROM_CHKSUM_EN).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  HPS download active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- dn_addr  out  ADDR_W  registered region-relative address.
- dn_data  out  8  registered byte.
- dn_wr  out  4  one-hot region write strobe.
- core_reset  out  1  reset to game core.
- load_done  out  1  valid image resident.
- load_error  out  1  last load failed.
- byte_cnt  out  ADDR_W  bytes accepted in current/last load.

Behaviour:
- Decided: one clock (clk_sys); reset is synchronous and active-high.
- Reset values: dn_addr=0, dn_data=0, dn_wr=0, core_reset=1, load_done=0, load_error=0, byte_cnt=0, state=IDLE.
- States: IDLE, LOAD, CHECK, HOLD, RUN, ERROR.
- IDLE: core_reset=1. Rising edge of ioctl_download -> LOAD. byte_cnt, overflow flag and checksum clear on entry to LOAD.
- LOAD:
  - core_reset=1, load_done=0.
  - Each ioctl_wr with ioctl_addr < TOTAL_BYTES: next cycle dn_wr one-hot set for the region containing the address, dn_addr = ioctl_addr - region base, dn_data = ioctl_dout. Latency exactly 1 cycle; strobe width 1 cycle. byte_cnt increments.
  - ioctl_wr with ioctl_addr >= TOTAL_BYTES: no dn_wr; sets overflow flag.
  - ioctl_addr bits [24:ADDR_W] nonzero count as out of range.
  - Falling edge of ioctl_download -> CHECK. A final ioctl_wr on the same cycle as the fall is still written.
- CHECK (1 cycle): pass iff byte_cnt == TOTAL_BYTES and overflow=0.
  - Pass -> HOLD, load_error=0.
  - Fail -> ERROR, load_error=1.
- HOLD: counter runs HOLD_CYC cycles with core_reset=1, then -> RUN.
- RUN: core_reset=0, load_done=1.
- ERROR: core_reset=1, load_done=0. load_error stays 1 until the next LOAD entry.
- Rising edge of ioctl_download in any state (HOLD, RUN, ERROR): -> LOAD the same cycle. core_reset=1 on the next cycle.
- Edge detection uses a registered copy of ioctl_download. That copy resets to 0, so a download already high out of reset enters LOAD one cycle after reset falls.
- reset mid-LOAD: abort, all outputs to reset values; any pending dn_wr is dropped.
- Region decode boundaries are inclusive at the base: addr == R1_BASE selects region 1.
- byte_cnt saturates at 2^ADDR_W-1.

Optional Feature:
- ROM_CHKSUM_EN defined:
  - 16-bit wrapping sum of every accepted byte (zero-extended) accumulates in LOAD.
  - CHECK additionally requires sum == EXP_SUM.
  - Sum readable on an extra output port chksum [15:0]; resets to 0.
- Undefined: no accumulator, no chksum port, and CHECK uses length/overflow only.

Test Plan:
- Length check: full 0x18000-byte download, ioctl_wr every 4 cycles.
  - Response: 0x18000 dn_wr pulses.
  - Byte 0x0C000 -> dn_wr=4'b0100, dn_addr=0.
  - Byte 0x0BFFF -> dn_wr=4'b0010, dn_addr=0x3FFF.
  - load_done=1 and core_reset=0 exactly HOLD_CYC+1 cycles after download falls.
- Short load: download stopped at 0x17FFF bytes -> load_error=1, core_reset stays 1, load_done=0.
- Overflow: extra write at addr 0x18000 -> no dn_wr; CHECK fails with load_error=1 even though byte_cnt=0x18000.
- Reload from RUN: ioctl_download rises -> core_reset=1 next cycle, load_done=0. A subsequent good load returns to RUN.
- Reset mid-load: reset asserted after 0x100 bytes.
  - All outputs at reset values, byte_cnt=0.
  - A new download completes normally.
- ROM_CHKSUM_EN: 0x18000 bytes of 0x01.
  - EXP_SUM=16'h8000 -> RUN.
  - EXP_SUM=16'h7FFF -> ERROR with chksum=16'h8000.
